vx_ag_tcu_uop_seq: RTL and testbench
====================================

// Module: VX_ag_tcu_uop_seq
// PURPOSE
//  Micro-op sequencer sitting directly upstream of the AG-TCU integer execute unit (issue side, before operand read).
//  Expands one tile-MMA instruction into M_STEPS*N_STEPS micro-ops, stamping step_m/step_n and per-step register numbers.
//  Each uop reads A sub-block m, B sub-block n, C/D fragment (m,n); the execute unit consumes step_m/step_n as block offsets.
//  Streams 1 uop/cycle under valid/ready backpressure; marks first/last uop with sop/eop.
// PARAMETERS
//  M_STEPS    4   A sub-blocks per instruction (1..16); default from VX_ag_tcu_pkg
//  N_STEPS    4   B sub-blocks per instruction (1..16); default from VX_ag_tcu_pkg
//  META_W     UUID_WIDTH+NW_WIDTH+PC_BITS   pass-through metadata width {uuid,wid,PC}
// PORTS
//  clk        in   1              clock
//  reset      in   1              synchronous, active-low (0 = reset)
//  in_valid   in   1              instruction valid
//  in_ready   out  1              instruction accepted when in_valid&&in_ready
//  in_meta    in   META_W         {uuid,wid,PC}, copied unchanged to every uop
//  in_rs1     in   NUM_REGS_BITS  A base register
//  in_rs2     in   NUM_REGS_BITS  B base register
//  in_rd      in   NUM_REGS_BITS  C/D base register (rs3 == rd, accumulate in place)
//  in_fmt_s   in   4              source format, copied unchanged
//  in_fmt_d   in   4              dest format, copied unchanged
//  out_valid  out  1              uop valid
//  out_ready  in   1              downstream ready
//  out_meta   out  META_W         latched in_meta
//  out_rs1/out_rs2/out_rs3/out_rd out NUM_REGS_BITS each  per-step registers
//  out_step_m out  4              m index;  out_step_n out 4  n index
//  out_fmt_s, out_fmt_d  out 4    latched formats
//  out_sop    out  1              first uop (m=0,n=0);  out_eop out 1  last uop
// BEHAVIOUR
//  Reset (reset==0 at clk edge): out_valid=0, in_ready=0 during reset, state IDLE, m=n=0; other outputs don't-care but registered 0.
//  States: IDLE (no held instruction) / BUSY (instruction latched, uops pending).
//  IDLE: in_ready=1; on in fire latch all in_* fields, m=n=0, -> BUSY; out_valid=1 next cycle (1-cycle latency).
//  BUSY: out_valid=1 continuously; outputs stable while out_valid&&!out_ready.
//  Order: n inner, m outer: (0,0),(0,1)..(0,N-1),(1,0)..(M-1,N-1); advance only on out fire.
//  Registers: rs1=in_rs1+m, rs2=in_rs2+n, rs3=rd=in_rd+m*N_STEPS+n; sums truncated mod 2^NUM_REGS_BITS (wrap, no error).
//  out_sop = (m==0&&n==0); out_eop = (m==M_STEPS-1&&n==N_STEPS-1); M=N=1 -> single uop, sop=eop=1.
//  in_ready = IDLE || (eop && out_ready): last-uop fire and new accept in same cycle -> stay BUSY, reload, m=n=0; zero bubble.
//  Last uop fires with no new in_valid -> IDLE, out_valid=0 next cycle.
//  Steady-state throughput 1 uop/cycle; instruction throughput 1 per M_STEPS*N_STEPS cycles.
//  All outputs driven from registers/counters only (no in_* -> out_* combinational path); in_ready depends on out_ready combinationally.
//  Reset mid-sequence: remaining uops discarded, out_valid=0 next cycle, no partial instruction resumes.
//  Multiplier m*N_STEPS is constant-param shift/add; counters 4-bit, compare against param-1.
// STRUCTURE
//  VX_ag_tcu_pkg: AG_TCU_M_STEPS, AG_TCU_N_STEPS (= A/B sub-block counts), step index width (4), uop field typedef ag_tcu_uop_t.
//  Single module; no sub-module needed (counter+datapath inline). Optional trace under DBG_TRACE_AG_TCU.
// TESTING
//  1) M=N=2, in_rs1=8,in_rs2=12,in_rd=16, out_ready=1 -> 4 uops cycles 1..4: (m,n,rs1,rs2,rd)=(0,0,8,12,16),(0,1,8,13,17),(1,0,9,12,18),(1,1,9,13,19); sop on 1st, eop on 4th.
//  2) Backpressure: out_ready low 3 cycles at uop 2 -> uop 2 fields held stable, no skip/duplicate, total fires=4.
//  3) Back-to-back: second instr valid during eop fire -> accepted same cycle, next cycle uop (0,0) of instr 2 with sop=1, no bubble.
//  4) Wrap: NUM_REGS_BITS=5, in_rd=30, M=N=2 -> rd sequence 30,31,0,1.
//  5) Reset (reset=0) after 2nd uop of 4 -> out_valid=0 next cycle; after release, new instr starts at (0,0) with sop=1.
//  6) M=N=1 -> each instr yields one uop with sop=eop=1; back-to-back instrs stream 1/cycle.

Source files
------------

// File: rtl/vx_ag_tcu_uop_seq_pkg.sv
// Shared constants and uop payload types for the AG-TCU micro-op sequencer.
package vx_ag_tcu_uop_seq_pkg;

  // A and B sub-block counts per tile-MMA instruction
  localparam int unsigned AG_TCU_M_STEPS = 4;
  localparam int unsigned AG_TCU_N_STEPS = 4;
  // Step index width (supports up to 16 sub-blocks per dimension)
  localparam int unsigned AG_TCU_STEP_W  = 4;
  // Source/destination format field width
  localparam int unsigned AG_TCU_FMT_W   = 4;
  // Flattened (m,n) fragment index width: 15*16+15 fits in 8 bits
  localparam int unsigned AG_TCU_IDX_W   = 8;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

  // Width-independent control part of one uop
  typedef struct packed {
    logic [AG_TCU_STEP_W-1:0] step_m;
    logic [AG_TCU_STEP_W-1:0] step_n;
    logic [AG_TCU_FMT_W-1:0]  fmt_s;
    logic [AG_TCU_FMT_W-1:0]  fmt_d;
    logic                     sop;
    logic                     eop;
  } ag_tcu_uop_t;

  // C/D fragment offset m*nsteps+n; nsteps is a parameter so this folds to shift/add
  function automatic logic [AG_TCU_IDX_W-1:0] ag_tcu_flat_idx(
    input logic [AG_TCU_STEP_W-1:0] m,
    input logic [AG_TCU_STEP_W-1:0] n,
    input int unsigned              nsteps
  );
    return AG_TCU_IDX_W'(m) * AG_TCU_IDX_W'(nsteps) + AG_TCU_IDX_W'(n);
  endfunction

endpackage

// File: rtl/vx_ag_tcu_uop_seq.sv
// Expands one tile-MMA instruction into M_STEPS*N_STEPS uops (n inner, m outer),
// streaming one uop per cycle under valid/ready with sop/eop framing.
module vx_ag_tcu_uop_seq
  import vx_ag_tcu_uop_seq_pkg::*;
#(
  parameter int unsigned M_STEPS       = AG_TCU_M_STEPS,
  parameter int unsigned N_STEPS       = AG_TCU_N_STEPS,
  parameter int unsigned META_W        = 32,
  parameter int unsigned NUM_REGS_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [META_W-1:0]        in_meta,
  input  logic [NUM_REGS_BITS-1:0] in_rs1,
  input  logic [NUM_REGS_BITS-1:0] in_rs2,
  input  logic [NUM_REGS_BITS-1:0] in_rd,
  input  logic [AG_TCU_FMT_W-1:0]  in_fmt_s,
  input  logic [AG_TCU_FMT_W-1:0]  in_fmt_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [META_W-1:0]        out_meta,
  output logic [NUM_REGS_BITS-1:0] out_rs1,
  output logic [NUM_REGS_BITS-1:0] out_rs2,
  output logic [NUM_REGS_BITS-1:0] out_rs3,
  output logic [NUM_REGS_BITS-1:0] out_rd,
  output logic [AG_TCU_STEP_W-1:0] out_step_m,
  output logic [AG_TCU_STEP_W-1:0] out_step_n,
  output logic [AG_TCU_FMT_W-1:0]  out_fmt_s,
  output logic [AG_TCU_FMT_W-1:0]  out_fmt_d,
  output logic                     out_sop,
  output logic                     out_eop
);

  localparam int unsigned REG_W = NUM_REGS_BITS;
  localparam logic [AG_TCU_STEP_W-1:0] M_LAST = AG_TCU_STEP_W'(M_STEPS - 1);
  localparam logic [AG_TCU_STEP_W-1:0] N_LAST = AG_TCU_STEP_W'(N_STEPS - 1);
  localparam logic SINGLE_UOP = (M_STEPS == 1) && (N_STEPS == 1);

  seq_state_e         state_q;
  logic               valid_q;
  ag_tcu_uop_t        uop_q;
  logic [META_W-1:0]  meta_q;
  logic [REG_W-1:0]   base_rs1_q, base_rs2_q, base_rd_q;
  logic [REG_W-1:0]   rs1_q, rs2_q, rd_q;

  logic                     in_fire, out_fire;
  logic [AG_TCU_STEP_W-1:0] m_d, n_d;
  logic [REG_W-1:0]         rs1_d, rs2_d, rd_d;
  logic                     eop_d;

  // Accept when idle, or when the last uop leaves this cycle (zero-bubble reload)
  assign in_ready = reset && ((state_q == SEQ_IDLE) || (uop_q.eop && out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid_q && out_ready;

  // Next (m,n) step and its register numbers, used when a non-last uop fires
  always_comb begin
    m_d   = uop_q.step_m;
    n_d   = uop_q.step_n + AG_TCU_STEP_W'(1);
    if (uop_q.step_n == N_LAST) begin
      n_d = '0;
      m_d = uop_q.step_m + AG_TCU_STEP_W'(1);
    end
    rs1_d = base_rs1_q + REG_W'(m_d);
    rs2_d = base_rs2_q + REG_W'(n_d);
    rd_d  = base_rd_q + REG_W'(ag_tcu_flat_idx(m_d, n_d, N_STEPS));
    eop_d = (m_d == M_LAST) && (n_d == N_LAST);
  end

  // Sequencer state, step counters and registered uop outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SEQ_IDLE;
      valid_q    <= 1'b0;
      uop_q      <= '0;
      meta_q     <= '0;
      base_rs1_q <= '0;
      base_rs2_q <= '0;
      base_rd_q  <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      if (in_fire) begin
        state_q      <= SEQ_BUSY;
        valid_q      <= 1'b1;
        meta_q       <= in_meta;
        base_rs1_q   <= in_rs1;
        base_rs2_q   <= in_rs2;
        base_rd_q    <= in_rd;
        rs1_q        <= in_rs1;
        rs2_q        <= in_rs2;
        rd_q         <= in_rd;
        uop_q.step_m <= '0;
        uop_q.step_n <= '0;
        uop_q.fmt_s  <= in_fmt_s;
        uop_q.fmt_d  <= in_fmt_d;
        uop_q.sop    <= 1'b1;
        uop_q.eop    <= SINGLE_UOP;
      end else begin
        case (state_q)
          SEQ_BUSY: begin
            if (out_fire) begin
              if (uop_q.eop) begin
                state_q <= SEQ_IDLE;
                valid_q <= 1'b0;
              end else begin
                uop_q.step_m <= m_d;
                uop_q.step_n <= n_d;
                uop_q.sop    <= 1'b0;
                uop_q.eop    <= eop_d;
                rs1_q        <= rs1_d;
                rs2_q        <= rs2_d;
                rd_q         <= rd_d;
              end
            end
          end
          default: begin
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_meta   = meta_q;
  assign out_rs1    = rs1_q;
  assign out_rs2    = rs2_q;
  assign out_rs3    = rd_q;
  assign out_rd     = rd_q;
  assign out_step_m = uop_q.step_m;
  assign out_step_n = uop_q.step_n;
  assign out_fmt_s  = uop_q.fmt_s;
  assign out_fmt_d  = uop_q.fmt_d;
  assign out_sop    = uop_q.sop;
  assign out_eop    = uop_q.eop;

endmodule

// File: tb/tb_vx_ag_tcu_uop_seq.sv
// Directed, table-driven bench for the AG-TCU uop sequencer (2x2 and 1x1 configs).
module tb_vx_ag_tcu_uop_seq;

  localparam int unsigned RB = 5;
  localparam int unsigned MW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2x2 instance signals
  logic          in_valid, in_ready, out_valid, out_ready, out_sop, out_eop;
  logic [MW-1:0] in_meta, out_meta;
  logic [RB-1:0] in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rs3, out_rd;
  logic [3:0]    in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d, out_step_m, out_step_n;

  // 1x1 instance signals
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sop, b_out_eop;
  logic [MW-1:0] b_out_meta;
  logic [RB-1:0] b_in_rs1, b_in_rs2, b_in_rd, b_out_rs1, b_out_rs2, b_out_rs3, b_out_rd;
  logic [3:0]    b_out_fmt_s, b_out_fmt_d, b_out_step_m, b_out_step_n;

  vx_ag_tcu_uop_seq #(.M_STEPS(2), .N_STEPS(2), .META_W(MW), .NUM_REGS_BITS(RB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_meta(in_meta), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d), .out_valid(out_valid), .out_ready(out_ready),
    .out_meta(out_meta), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_rd(out_rd), .out_step_m(out_step_m), .out_step_n(out_step_n),
    .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d), .out_sop(out_sop), .out_eop(out_eop)
  );

  vx_ag_tcu_uop_seq #(.M_STEPS(1), .N_STEPS(1), .META_W(MW), .NUM_REGS_BITS(RB)) dut1 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_meta(8'h3C), .in_rs1(b_in_rs1), .in_rs2(b_in_rs2), .in_rd(b_in_rd),
    .in_fmt_s(4'd1), .in_fmt_d(4'd2), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_meta(b_out_meta), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rs3(b_out_rs3),
    .out_rd(b_out_rd), .out_step_m(b_out_step_m), .out_step_n(b_out_step_n),
    .out_fmt_s(b_out_fmt_s), .out_fmt_d(b_out_fmt_d), .out_sop(b_out_sop), .out_eop(b_out_eop)
  );

  typedef struct {
    logic          iv;
    logic [RB-1:0] rs1, rs2, rd;
    logic          ordy;
    logic          irdy;   // expected in_ready before the edge
    logic          ov;     // expected out_valid after the edge
    logic [3:0]    m, n;
    logic [RB-1:0] ers1, ers2, erd;
    logic          sop, eop;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int iv, input int rs1, input int rs2, input int rd,
                              input int ordy, input int irdy, input int ov, input int m,
                              input int n, input int ers1, input int ers2, input int erd,
                              input int sop, input int eop);
    vec_t v;
    v.iv = 1'(iv); v.rs1 = RB'(rs1); v.rs2 = RB'(rs2); v.rd = RB'(rd);
    v.ordy = 1'(ordy); v.irdy = 1'(irdy); v.ov = 1'(ov);
    v.m = 4'(m); v.n = 4'(n); v.ers1 = RB'(ers1); v.ers2 = RB'(ers2); v.erd = RB'(erd);
    v.sop = 1'(sop); v.eop = 1'(eop);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] obs();
    return {out_valid, out_step_m, out_step_n, out_rs1, out_rs2, out_rs3, out_rd, out_sop, out_eop};
  endfunction

  function automatic logic [30:0] expv(input logic [3:0] m, input logic [3:0] n,
                                       input logic [RB-1:0] r1, input logic [RB-1:0] r2,
                                       input logic [RB-1:0] rd, input logic sop, input logic eop);
    return {1'b1, m, n, r1, r2, rd, rd, sop, eop};
  endfunction

  initial begin
    // iv rs1 rs2 rd ordy | irdy ov m n rs1 rs2 rd sop eop
    // basic 2x2 sequence
    vecs[0]  = mk(1,  8, 12, 16, 1,  1, 1, 0, 0,  8, 12, 16, 1, 0);
    vecs[1]  = mk(0,  0,  0,  0, 1,  0, 1, 0, 1,  8, 13, 17, 0, 0);
    vecs[2]  = mk(0,  0,  0,  0, 1,  0, 1, 1, 0,  9, 12, 18, 0, 0);
    vecs[3]  = mk(0,  0,  0,  0, 1,  0, 1, 1, 1,  9, 13, 19, 0, 1);
    vecs[4]  = mk(0,  0,  0,  0, 1,  1, 0, 0, 0,  0,  0,  0, 0, 0);
    // backpressure on uop 2 for three cycles
    vecs[5]  = mk(1,  2,  4,  6, 1,  1, 1, 0, 0,  2,  4,  6, 1, 0);
    vecs[6]  = mk(0,  0,  0,  0, 1,  0, 1, 0, 1,  2,  5,  7, 0, 0);
    vecs[7]  = mk(0,  0,  0,  0, 0,  0, 1, 0, 1,  2,  5,  7, 0, 0);
    vecs[8]  = mk(0,  0,  0,  0, 0,  0, 1, 0, 1,  2,  5,  7, 0, 0);
    vecs[9]  = mk(0,  0,  0,  0, 0,  0, 1, 0, 1,  2,  5,  7, 0, 0);
    vecs[10] = mk(0,  0,  0,  0, 1,  0, 1, 1, 0,  3,  4,  8, 0, 0);
    vecs[11] = mk(0,  0,  0,  0, 1,  0, 1, 1, 1,  3,  5,  9, 0, 1);
    // back-to-back accept during eop fire; rd wraps 30,31,0,1
    vecs[12] = mk(1, 10, 11, 30, 1,  1, 1, 0, 0, 10, 11, 30, 1, 0);
    vecs[13] = mk(0,  0,  0,  0, 1,  0, 1, 0, 1, 10, 12, 31, 0, 0);
    vecs[14] = mk(0,  0,  0,  0, 1,  0, 1, 1, 0, 11, 11,  0, 0, 0);
    vecs[15] = mk(0,  0,  0,  0, 1,  0, 1, 1, 1, 11, 12,  1, 0, 1);
    // eop stalled: new instr must wait
    vecs[16] = mk(1, 31, 31, 31, 0,  0, 1, 1, 1, 11, 12,  1, 0, 1);
    vecs[17] = mk(1, 31, 31, 31, 1,  1, 1, 0, 0, 31, 31, 31, 1, 0);
    vecs[18] = mk(0,  0,  0,  0, 1,  0, 1, 0, 1, 31,  0,  0, 0, 0);
    vecs[19] = mk(0,  0,  0,  0, 1,  0, 1, 1, 0,  0, 31,  1, 0, 0);
    vecs[20] = mk(0,  0,  0,  0, 1,  0, 1, 1, 1,  0,  0,  2, 0, 1);
    vecs[21] = mk(0,  0,  0,  0, 1,  1, 0, 0, 0,  0,  0,  0, 0, 0);
    vecs[22] = mk(0,  0,  0,  0, 1,  1, 0, 0, 0,  0,  0,  0, 0, 0);

    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_meta = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_fmt_s = 4'd0; in_fmt_d = 4'd0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_rs1 = '0; b_in_rs2 = '0; b_in_rd = '0;

    // reset state
    in_valid = 1'b1;
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // table-driven sequences
    for (int i = 0; i < NV; i++) begin
      in_valid = vecs[i].iv; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
      in_rd = vecs[i].rd; out_ready = vecs[i].ordy;
      in_meta = MW'(i); in_fmt_s = 4'd5; in_fmt_d = 4'd6;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].irdy));
      step();
      if (vecs[i].ov)
        chk($sformatf("v%0d_uop", i), 64'(obs()),
            64'(expv(vecs[i].m, vecs[i].n, vecs[i].ers1, vecs[i].ers2, vecs[i].erd,
                     vecs[i].sop, vecs[i].eop)));
      else
        chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(0));
    end

    // metadata/format pass-through, then reset mid-sequence
    in_valid = 1'b1; in_meta = 8'hA5; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3;
    in_fmt_s = 4'd3; in_fmt_d = 4'd9; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_meta = 8'h00; in_fmt_s = 4'd0; in_fmt_d = 4'd0;
    chk("meta_uop1", 64'(out_meta), 64'(8'hA5));
    chk("fmt_uop1", 64'({out_fmt_s, out_fmt_d}), 64'({4'd3, 4'd9}));
    chk("rs_uop1", 64'(obs()), 64'(expv(0, 0, 1, 2, 3, 1, 0)));
    step();
    chk("rs_uop2", 64'(obs()), 64'(expv(0, 1, 1, 3, 4, 0, 0)));
    chk("meta_uop2", 64'(out_meta), 64'(8'hA5));
    step();
    reset = 1'b0; in_valid = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    reset = 1'b1; in_valid = 1'b1; in_rs1 = 5'd4; in_rs2 = 5'd5; in_rd = 5'd6;
    step();
    in_valid = 1'b0;
    chk("after_rst_uop", 64'(obs()), 64'(expv(0, 0, 4, 5, 6, 1, 0)));
    step();
    chk("after_rst_uop2", 64'(obs()), 64'(expv(0, 1, 4, 6, 7, 0, 0)));
    out_ready = 1'b1;
    step(); step(); step();
    chk("after_rst_drain", 64'(out_valid), 64'(0));

    // 1x1 config: every uop is sop+eop, instructions stream back to back
    b_in_valid = 1'b1; b_in_rs1 = 5'd5; b_in_rs2 = 5'd6; b_in_rd = 5'd7;
    step();
    b_in_rs1 = 5'd8; b_in_rs2 = 5'd9; b_in_rd = 5'd10;
    chk("one_uop1", 64'({b_out_valid, b_out_step_m, b_out_step_n, b_out_rs1, b_out_rs2,
                         b_out_rs3, b_out_rd, b_out_sop, b_out_eop}),
        64'({1'b1, 4'd0, 4'd0, 5'd5, 5'd6, 5'd7, 5'd7, 1'b1, 1'b1}));
    chk("one_meta", 64'({b_out_meta, b_out_fmt_s, b_out_fmt_d}), 64'({8'h3C, 4'd1, 4'd2}));
    #1;
    chk("one_in_ready", 64'(b_in_ready), 64'(1));
    step();
    b_in_valid = 1'b0;
    chk("one_uop2", 64'({b_out_valid, b_out_rs1, b_out_rs2, b_out_rd, b_out_sop, b_out_eop}),
        64'({1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1}));
    step();
    chk("one_idle", 64'(b_out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
